reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 15-entry Y86 register file (IDs 0x0–0xE; 0xF = "no register").
- Sits between decode and the register file. Decode presents each instruction's srcA/srcB/dstE/dstM.
- Grants issue only when neither source has a pending write and the destination counters have room.
- Execute and memory stages report write completions on the E and M writeback ports.

Parameters:
- MAX_PENDING, 3: maximum outstanding writes per register. Range 1–3; each per-register counter is 2 bits.
- TOTAL_W, 6: width of pending_total. Must hold 15*MAX_PENDING.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- issue_valid  in  1  decode presents an instruction.
- issue_srcA  in  4  source A register ID; 0xF = none.
- issue_srcB  in  4  source B register ID; 0xF = none.
- issue_dstE  in  4  E destination ID; 0xF = none.
- issue_dstM  in  4  M destination ID; 0xF = none.
- issue_ready  out  1  combinational grant; an issue is accepted when issue_valid & issue_ready.
- wb_valid_E  in  1  E-port write completes this cycle.
- wb_dstE  in  4  E-port written register.
- wb_valid_M  in  1  M-port write completes this cycle.
- wb_dstM  in  4  M-port written register.
- busy_mask  out  15  registered; bit i = (count[i] != 0).
- pending_total  out  TOTAL_W  registered; sum of all counters.
- idle  out  1  registered; pending_total == 0.
- err  out  1  registered, sticky; writeback to a register whose count is 0.

Behaviour:
- State: count[0..14], 2 bits each. All outputs derive from this state except issue_ready.
- Reset (synchronous, active-high):
  - All counts 0, busy_mask 0, pending_total 0, idle 1, err 0.
  - issue_ready forced 0 while reset is high.
  - A reset asserted mid-operation discards all pending state on that edge. Writebacks in the same cycle are ignored.
- Hazard check: uses registered counts only (pre-update), unless WB_BYPASS_EN is defined.
  - srcA blocks if srcA != 0xF and count[srcA] != 0. srcB likewise.
- Capacity check:
  - inc[r] = (dstE==r) + (dstM==r), over non-0xF IDs. When dstE == dstM, inc = 2 for that register.
  - Blocks if count[r] + inc[r] > MAX_PENDING for any r.
- issue_ready = !reset & no source hazard & no capacity violation. It does not depend on issue_valid.
- Per-cycle update for each register r:
  - next = count[r] + acc*inc[r] - dec[r], where acc = issue_valid & issue_ready.
  - dec[r] = (wb_valid_E & wb_dstE==r) + (wb_valid_M & wb_dstM==r). When both ports hit r, dec = 2.
  - Writeback IDs of 0xF are ignored even when their valid is high.
  - Issue and writeback to the same register in the same cycle net out (e.g. +1 −1 = unchanged).
- Underflow: if dec[r] exceeds count[r] + acc*inc[r], count saturates at 0 and err sets. err holds until reset.
- Self-dependency, e.g. srcA == dstE == r with count[r] = 0:
  - Allowed to issue; the source check sees count 0.
  - The next instruction reading r stalls until writeback.
- Latency:
  - Issue acceptance to busy_mask bit set: 1 cycle.
  - Writeback to busy_mask bit clear: 1 cycle.
  - Without bypass, a reader stalled on r gets issue_ready the cycle after the final writeback of r.
- pending_total / idle are updated on the same edge as the counters.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: the hazard check uses count[r] - dec[r] (floored at 0) for the current cycle. A reader whose last pending write completes this cycle gets issue_ready in that same cycle.
  - Matches a register file that writes before it reads within a cycle.
  - The capacity check also uses the post-writeback count.
- Undefined: checks use registered counts only. This adds one stall cycle but gives no combinational path from wb_* to issue_ready.

Test Plan:
- Reset, then idle inputs: busy_mask=0, pending_total=0, idle=1, err=0, issue_ready=1. Hold reset high: issue_ready=0.
- Issue dstE=0x3 (srcs 0xF). Next cycle issue srcA=0x3: issue_ready=0 and busy_mask=0x0008. wb_valid_E with wb_dstE=0x3: one cycle later busy_mask=0, then issue_ready=1. With bypass, issue_ready=1 in the writeback cycle.
- Issue dstE=dstM=0x4 three cycles in a row with MAX_PENDING=3: the first issue is accepted (count=2), the second is blocked (2+2>3), and pending_total=2. A single E writeback to 0x4 takes count to 1; then an issue with dstE=dstM=0x4 is accepted again (count=3).
- Same cycle: issue dstE=0x1 accepted and wb_valid_M with wb_dstM=0x1 while count[1]=1: count[1] stays 1, pending_total unchanged.
- wb_valid_E with wb_dstE=0x7 while count[7]=0: err=1 next cycle and count[7] stays 0. err holds through later traffic until reset.
- wb_valid_E=1 with wb_dstE=0xF and issue_dstE=0xF with issue_valid: no counter changes and err stays 0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard for the 15-entry Y86 register file; gates decode issue on RAW hazards and per-register capacity.
// Optional macro SCOREBOARD_WB_BYPASS_EN: hazard/capacity checks see this cycle's writebacks.
module reg_scoreboard #(
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned TOTAL_W     = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [3:0]         issue_srcA,
  input  logic [3:0]         issue_srcB,
  input  logic [3:0]         issue_dstE,
  input  logic [3:0]         issue_dstM,
  output logic               issue_ready,
  input  logic               wb_valid_E,
  input  logic [3:0]         wb_dstE,
  input  logic               wb_valid_M,
  input  logic [3:0]         wb_dstM,
  output logic [14:0]        busy_mask,
  output logic [TOTAL_W-1:0] pending_total,
  output logic               idle,
  output logic               err
);

  localparam int unsigned NREG  = 15;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0]   count_q [NREG];
  logic [CNT_W-1:0]   count_d [NREG];
  logic [NREG-1:0]    busy_q, busy_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               idle_q, idle_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0] inc  [NREG];
  logic [CNT_W-1:0] dec  [NREG];
  logic [CNT_W-1:0] base [NREG];
  logic             haz_a, haz_b, cap_bad, acc;
  logic [SUM_W-1:0] sum;

  // Per-register increments/decrements, hazard and capacity checks, next-state counters
  always_comb begin
    haz_a   = 1'b0;
    haz_b   = 1'b0;
    cap_bad = 1'b0;
    busy_d  = '0;
    total_d = '0;
    err_d   = err_q;
    sum     = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      // ID 0xF never matches r < 15, so "no register" drops out naturally
      inc[r] = CNT_W'(issue_dstE == 4'(r)) + CNT_W'(issue_dstM == 4'(r));
      dec[r] = CNT_W'(wb_valid_E && (wb_dstE == 4'(r)))
             + CNT_W'(wb_valid_M && (wb_dstM == 4'(r)));
`ifdef SCOREBOARD_WB_BYPASS_EN
      base[r] = (count_q[r] > dec[r]) ? (count_q[r] - dec[r]) : '0;
`else
      base[r] = count_q[r];
`endif
      if ((issue_srcA == 4'(r)) && (base[r] != '0)) haz_a = 1'b1;
      if ((issue_srcB == 4'(r)) && (base[r] != '0)) haz_b = 1'b1;
      if ((SUM_W'(base[r]) + SUM_W'(inc[r])) > SUM_W'(MAX_PENDING)) cap_bad = 1'b1;
    end

    issue_ready = !reset && !haz_a && !haz_b && !cap_bad;
    acc         = issue_valid && issue_ready;

    for (int unsigned r = 0; r < NREG; r++) begin
      sum = SUM_W'(count_q[r]) + (acc ? SUM_W'(inc[r]) : '0);
      if (SUM_W'(dec[r]) > sum) begin
        count_d[r] = '0;
        err_d      = 1'b1;
      end else begin
        count_d[r] = CNT_W'(sum - SUM_W'(dec[r]));
      end
      busy_d[r] = (count_d[r] != '0);
      total_d   = total_d + TOTAL_W'(count_d[r]);
    end
    idle_d = (total_d == '0);
  end

  // State register; reset discards pending state and same-cycle writebacks
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) count_q[r] <= '0;
      busy_q  <= '0;
      total_q <= '0;
      idle_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) count_q[r] <= count_d[r];
      busy_q  <= busy_d;
      total_q <= total_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  assign busy_mask     = busy_q;
  assign pending_total = total_q;
  assign idle          = idle_q;
  assign err           = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: reference counter model feeds an expected-state queue.
module tb_reg_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_srcA, issue_srcB, issue_dstE, issue_dstM;
  logic        issue_ready;
  logic        wb_valid_E, wb_valid_M;
  logic [3:0]  wb_dstE, wb_dstM;
  logic [14:0] busy_mask;
  logic [5:0]  pending_total;
  logic        idle, err;

  reg_scoreboard #(.MAX_PENDING(3), .TOTAL_W(6)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .issue_srcA(issue_srcA), .issue_srcB(issue_srcB),
    .issue_dstE(issue_dstE), .issue_dstM(issue_dstM),
    .issue_ready(issue_ready),
    .wb_valid_E(wb_valid_E), .wb_dstE(wb_dstE),
    .wb_valid_M(wb_valid_M), .wb_dstM(wb_dstM),
    .busy_mask(busy_mask), .pending_total(pending_total),
    .idle(idle), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [14:0] busy;
    logic [5:0]  total;
    logic        idle;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   cnt [15];
  bit   m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // One cycle: drive, check the combinational grant, advance the model, compare registered state.
  // want_rdy < 0 means only the model's prediction is checked.
  task automatic step(input bit rst, input bit v, input logic [3:0] sa, input logic [3:0] sb,
                      input logic [3:0] de, input logic [3:0] dm,
                      input bit wve, input logic [3:0] wde, input bit wvm, input logic [3:0] wdm,
                      input int want_rdy);
    int   inc [15];
    int   dec [15];
    int   base [15];
    bit   rdy;
    exp_t e;
    exp_t got;
    reset = rst; issue_valid = v;
    issue_srcA = sa; issue_srcB = sb; issue_dstE = de; issue_dstM = dm;
    wb_valid_E = wve; wb_dstE = wde; wb_valid_M = wvm; wb_dstM = wdm;
    #1;
    rdy = !rst;
    for (int r = 0; r < 15; r++) begin
      inc[r] = (int'(de) == r ? 1 : 0) + (int'(dm) == r ? 1 : 0);
      dec[r] = ((wve && int'(wde) == r) ? 1 : 0) + ((wvm && int'(wdm) == r) ? 1 : 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
      base[r] = (cnt[r] > dec[r]) ? cnt[r] - dec[r] : 0;
`else
      base[r] = cnt[r];
`endif
      if (int'(sa) == r && base[r] != 0) rdy = 0;
      if (int'(sb) == r && base[r] != 0) rdy = 0;
      if (base[r] + inc[r] > 3) rdy = 0;
    end
    check_eq("issue_ready_model", 32'(issue_ready), 32'(rdy));
    if (want_rdy >= 0) check_eq("issue_ready_const", 32'(issue_ready), 32'(want_rdy));
    e.busy = '0; e.total = '0;
    for (int r = 0; r < 15; r++) begin
      int s;
      s = cnt[r] + ((v && rdy) ? inc[r] : 0);
      if (rst) cnt[r] = 0;
      else if (dec[r] > s) begin cnt[r] = 0; m_err = 1; end
      else cnt[r] = s - dec[r];
      if (cnt[r] != 0) e.busy[r] = 1'b1;
      e.total = e.total + 6'(cnt[r]);
    end
    if (rst) m_err = 0;
    e.idle = (e.total == 0);
    e.err  = m_err;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    check_eq("busy_mask", 32'(busy_mask), 32'(got.busy));
    check_eq("pending_total", 32'(pending_total), 32'(got.total));
    check_eq("idle", 32'(idle), 32'(got.idle));
    check_eq("err", 32'(err), 32'(got.err));
  endtask

  task automatic nop(input int want_rdy);
    step(0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, want_rdy);
  endtask

  initial begin
    logic [3:0] F;
    F = 4'hF;
    for (int r = 0; r < 15; r++) cnt[r] = 0;
    m_err = 0;

    // Reset held high: grant forced low
    step(1, 1, F, F, F, F, 0, F, 0, F, 0);
    step(1, 1, F, F, 4'h2, F, 1, 4'h2, 0, F, 0);
    nop(1);
    check_eq("reset_busy", 32'(busy_mask), 32'h0);
    check_eq("reset_idle", 32'(idle), 32'h1);

    // RAW stall on r3 and release after writeback
    step(0, 1, F, F, 4'h3, F, 0, F, 0, F, 1);
    step(0, 1, 4'h3, F, F, F, 0, F, 0, F, 0);
    check_eq("busy_r3", 32'(busy_mask), 32'h0008);
`ifdef SCOREBOARD_WB_BYPASS_EN
    step(0, 1, 4'h3, F, F, F, 1, 4'h3, 0, F, 1);
`else
    step(0, 1, 4'h3, F, F, F, 1, 4'h3, 0, F, 0);
`endif
    check_eq("busy_clear_r3", 32'(busy_mask), 32'h0);
    step(0, 1, 4'h3, F, F, F, 0, F, 0, F, 1);

    // Capacity: dstE == dstM == r4 counts twice
    step(0, 1, F, F, 4'h4, 4'h4, 0, F, 0, F, 1);
    step(0, 1, F, F, 4'h4, 4'h4, 0, F, 0, F, 0);
    step(0, 1, F, F, 4'h4, 4'h4, 0, F, 0, F, 0);
    check_eq("cap_total2", 32'(pending_total), 32'd2);
    step(0, 0, F, F, F, F, 1, 4'h4, 0, F, -1);
    check_eq("cap_total1", 32'(pending_total), 32'd1);
    step(0, 1, F, F, 4'h4, 4'h4, 0, F, 0, F, 1);
    check_eq("cap_total3", 32'(pending_total), 32'd3);
    step(0, 0, F, F, F, F, 1, 4'h4, 1, 4'h4, -1);
    step(0, 0, F, F, F, F, 1, 4'h4, 0, F, -1);
    check_eq("cap_drain", 32'(pending_total), 32'd0);

    // Same-cycle issue and writeback on r1 net out
    step(0, 1, F, F, 4'h1, F, 0, F, 0, F, 1);
    step(0, 1, F, F, 4'h1, F, 0, F, 1, 4'h1, 1);
    check_eq("net_total", 32'(pending_total), 32'd1);
    check_eq("net_busy", 32'(busy_mask), 32'h0002);
    step(0, 0, F, F, F, F, 0, F, 1, 4'h1, -1);

    // Self-dependency issues; the next reader stalls
    step(0, 1, 4'h5, F, 4'h5, F, 0, F, 0, F, 1);
    step(0, 1, 4'h5, F, F, F, 0, F, 0, F, 0);
    step(0, 0, F, F, F, F, 1, 4'h5, 0, F, -1);

    // Underflow on r7 sets sticky err
    step(0, 0, F, F, F, F, 1, 4'h7, 0, F, -1);
    check_eq("err_set", 32'(err), 32'h1);
    check_eq("err_r7_zero", 32'(busy_mask[7]), 32'h0);
    step(0, 1, F, F, 4'h7, F, 0, F, 0, F, 1);
    step(0, 0, F, F, F, F, 1, 4'h7, 0, F, -1);
    check_eq("err_hold", 32'(err), 32'h1);
    step(1, 0, F, F, F, F, 1, 4'h7, 0, F, 0);
    check_eq("err_cleared", 32'(err), 32'h0);

    // Writeback / issue to 0xF: no effect
    step(0, 1, F, F, F, F, 1, F, 1, F, 1);
    check_eq("nullreg_total", 32'(pending_total), 32'd0);
    check_eq("nullreg_err", 32'(err), 32'h0);

    // Mid-operation reset discards pending writes
    step(0, 1, F, F, 4'h9, 4'hA, 0, F, 0, F, 1);
    step(1, 0, F, F, F, F, 1, 4'h9, 0, F, 0);
    check_eq("midreset_total", 32'(pending_total), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] sa, sb, de, dm, wde, wdm;
      bit v, wve, wvm;
      sa  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : F;
      sb  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : F;
      de  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 14)) : F;
      dm  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : F;
      v   = 1'($urandom_range(0, 1));
      wve = ($urandom_range(0, 2) != 0);
      wvm = ($urandom_range(0, 3) == 0);
      wde = 4'($urandom_range(0, 15));
      wdm = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), v, sa, sb, de, dm, wve, wde, wvm, wdm, -1);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
